// File: rtl/serial_adder_pkg.sv
// Shared types and width helpers for the bit-serial add sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_IDX_W = 1;

    // Bit-slice counter width: enough to reach WIDTH-1, never narrower than one bit.
    function automatic int idx_width(input int width);
        return (width <= 1) ? MIN_IDX_W : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder, time-shared by the serial sequencer.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one full-adder cell, LSB-first over WIDTH cycles.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for A-B via inverted B and carry-in of 1.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, result_q;
    logic [WIDTH-1:0] sum_msb;
    logic             carry_q, cout_q;
    logic             cell_sum, cell_cout;
    logic             sub_mode;
    logic             accept, last_slice;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_mode = sub;
`else
    assign sub_mode = 1'b0;
`endif

    assign accept     = start_valid && (state_q == IDLE);
    assign last_slice = (bit_idx_q == LAST_IDX);

    full_adder_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // Sum bit positioned at the MSB; written bitwise so WIDTH=1 needs no special case.
    always_comb begin
        sum_msb          = '0;
        sum_msb[WIDTH-1] = cell_sum;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (last_slice)  state_d = DONE;
            DONE:    if (res_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: all datapath registers are reset too; result/cout are visible outputs with defined reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_q <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
        end else if (accept) begin
            bit_idx_q <= '0;
            a_sh_q    <= op_a;
            b_sh_q    <= op_b ^ {WIDTH{sub_mode}};
            carry_q   <= sub_mode ? 1'b1 : cin;
            result_q  <= '0;
            cout_q    <= 1'b0;
        end else if (state_q == RUN) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            carry_q  <= cell_cout;
            result_q <= (result_q >> 1) | sum_msb;
            if (last_slice) cout_q    <= cell_cout;
            else            bit_idx_q <= bit_idx_q + IDX_W'(1);
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); define SERIAL_ADD_SUB_EN to add subtract vectors.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after res_valid rises.
    // lat counts edges from (and including) the accepting edge.
    task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s, input bit scramble);
        int lat;
        check({tag, ".start_ready"}, 32'(start_ready), 32'd1);
        op_a = a; op_b = b; cin = c; sub = s;
        start_valid = 1'b1;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start_valid = 1'b0;
            if (lat == 1) begin
                check({tag, ".busy_run"}, 32'(busy), 32'd1);
                check({tag, ".ready_run"}, 32'(start_ready), 32'd0);
            end
            if (scramble) begin
                op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'd9);
    endtask

    task automatic finish_result(input string tag, input logic [7:0] exp_res, input logic exp_co);
        check({tag, ".result"}, 32'(result), 32'(exp_res));
        check({tag, ".cout"}, 32'(cout), 32'(exp_co));
        check({tag, ".busy_done"}, 32'(busy), 32'd1);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, ".idle_valid"}, 32'(res_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        #1;
        check("rst.start_ready", 32'(start_ready), 32'd1);
        check("rst.res_valid", 32'(res_valid), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue("t1", 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
        finish_result("t1", 8'h8D, 1'b0);

        issue("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        finish_result("t2a", 8'h00, 1'b1);
        issue("t2b", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        finish_result("t2b", 8'h01, 1'b0);

        // Backpressure: hold DONE with stray start pulses; nothing may change.
        issue("t3", 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start_valid = i[0];
            op_a = 8'hC3; op_b = 8'h3C; cin = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("t3.hold_valid", 32'(res_valid), 32'd1);
            check("t3.hold_result", 32'(result), 32'h8D);
            check("t3.hold_cout", 32'(cout), 32'd0);
            check("t3.hold_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        finish_result("t3", 8'h8D, 1'b0);

        issue("t4", 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        finish_result("t4", 8'h30, 1'b0);

        // Abort mid-RUN: bit_idx reaches 3 three edges after acceptance.
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5.busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5.rst_ready", 32'(start_ready), 32'd1);
        check("t5.rst_valid", 32'(res_valid), 32'd0);
        check("t5.rst_result", 32'(result), 32'd0);
        check("t5.rst_cout", 32'(cout), 32'd0);
        check("t5.rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue("t5", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        finish_result("t5", 8'h02, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        issue("t6a", 8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        finish_result("t6a", 8'h0F, 1'b1);
        issue("t6b", 8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
        finish_result("t6b", 8'hFF, 1'b0);
        issue("t6c", 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
        finish_result("t6c", 8'h8D, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
